pinc_stream_monitor: RTL and testbench

PINC_STREAM_MONITOR -- requirements
Module: pinc_stream_monitor

---
 rtl/pinc_stream_monitor.sv | 183 ++++++++++++++++++
 tb/tb_pinc_stream_monitor.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pinc_stream_monitor.sv
// pinc_stream_monitor
// Watches a chirp generator's phase-increment stream. It tracks each chirp as
// a run of consecutive valid cycles, and checks two things: that each value is
// held for the latched expected dwell, and that consecutive values differ by
// STEP. It reports first/last values, the number of steps, sticky error flags
// and a saturating error count.
// Optional feature: define PINC_MON_HIST_EN to add a history RAM that captures
// each chirp's first value and every changed value, with a registered read
// port. Without the macro, hist_data is tied to 0 and hist_addr is ignored.
`timescale 1ns/1ps

module pinc_stream_monitor #(
   parameter int DATA_W     = 24,
   parameter int CNT_W      = 32,
   parameter int STEP       = 1,
   parameter int HIST_DEPTH = 512,
   localparam int HIST_AW   = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DATA_W-1:0]  s_axis_tdata,
   input  logic               s_axis_tvalid,
   output logic               s_axis_tready,
   input  logic [CNT_W-1:0]   expected_dwell,
   input  logic               clear,
   output logic               chirp_active,
   output logic               chirp_done,
   output logic [DATA_W-1:0]  pinc_first,
   output logic [DATA_W-1:0]  pinc_last,
   output logic [15:0]        step_count,
   output logic               dwell_err,
   output logic               step_err,
   output logic [15:0]        err_count,
   input  logic [HIST_AW-1:0] hist_addr,
   output logic [DATA_W-1:0]  hist_data
);

   typedef enum logic [1:0] {WAIT_LOW, IDLE, RUN, DONE} state_t;

   localparam logic [DATA_W-1:0] STEP_D  = DATA_W'(STEP);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;

   state_t            state;
   logic [DATA_W-1:0] prev;
   logic [CNT_W-1:0]  dwell_cnt;
   logic [CNT_W-1:0]  exp_lat;

   logic              start;
   logic              change;
   logic              dwell_chk;
   logic              dwell_fail;
   logic              step_fail;
   logic [1:0]        err_inc;
   logic [16:0]       err_sum;

   // Event decode: a dwell check happens whenever the held value ends, either
   // because a new value arrived or because the chirp ended.
   always_comb begin
      start      = (state == IDLE) && s_axis_tvalid;
      change     = (state == RUN) && s_axis_tvalid && (s_axis_tdata != prev);
      dwell_chk  = (state == RUN) && !(s_axis_tvalid && (s_axis_tdata == prev));
      dwell_fail = dwell_chk && (exp_lat != '0) && (dwell_cnt != exp_lat);
      step_fail  = change && (s_axis_tdata != (prev + STEP_D));
      err_inc    = {1'b0, dwell_fail} + {1'b0, step_fail};
      err_sum    = {1'b0, err_count} + {15'd0, err_inc};
   end

   // Chirp FSM, per-chirp statistics, and sticky error bookkeeping (clear wins
   // over anything detected in the same cycle).
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= WAIT_LOW;
         s_axis_tready <= 1'b0;
         chirp_active  <= 1'b0;
         chirp_done    <= 1'b0;
         pinc_first    <= '0;
         pinc_last     <= '0;
         step_count    <= '0;
         prev          <= '0;
         dwell_cnt     <= '0;
         exp_lat       <= '0;
         dwell_err     <= 1'b0;
         step_err      <= 1'b0;
         err_count     <= '0;
      end else begin
         s_axis_tready <= 1'b1;
         chirp_done    <= 1'b0;
         case (state)
            WAIT_LOW: begin
               if (!s_axis_tvalid) state <= IDLE;
            end
            IDLE: begin
               if (s_axis_tvalid) begin
                  state        <= RUN;
                  chirp_active <= 1'b1;
                  pinc_first   <= s_axis_tdata;
                  prev         <= s_axis_tdata;
                  dwell_cnt    <= CNT_ONE;
                  step_count   <= '0;
                  exp_lat      <= expected_dwell;
               end
            end
            RUN: begin
               if (s_axis_tvalid) begin
                  if (s_axis_tdata == prev) begin
                     if (dwell_cnt != CNT_MAX) dwell_cnt <= dwell_cnt + CNT_ONE;
                  end else begin
                     prev      <= s_axis_tdata;
                     dwell_cnt <= CNT_ONE;
                     if (step_count != 16'hFFFF) step_count <= step_count + 16'd1;
                  end
               end else begin
                  state        <= DONE;
                  chirp_active <= 1'b0;
                  chirp_done   <= 1'b1;
                  pinc_last    <= prev;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= WAIT_LOW;
            end
         endcase
         if (clear) begin
            dwell_err <= 1'b0;
            step_err  <= 1'b0;
            err_count <= '0;
         end else begin
            if (dwell_fail) dwell_err <= 1'b1;
            if (step_fail) step_err <= 1'b1;
            err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
         end
      end
   end

`ifdef PINC_MON_HIST_EN
   localparam logic [HIST_AW:0] DEPTH_P = (HIST_AW + 1)'(HIST_DEPTH);

   logic [DATA_W-1:0] hist_mem [HIST_DEPTH];
   logic [HIST_AW:0]  wr_ptr;

   // Write pointer restarts at every chirp and parks at the depth so that
   // later values are dropped rather than wrapping over earlier ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
      end else if (start) begin
         wr_ptr <= (HIST_AW + 1)'(1);
      end else if (change && (wr_ptr != DEPTH_P)) begin
         wr_ptr <= wr_ptr + (HIST_AW + 1)'(1);
      end
   end

   // History storage has no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (!rst && start) begin
         hist_mem[0] <= s_axis_tdata;
      end else if (!rst && change && (wr_ptr < DEPTH_P)) begin
         hist_mem[wr_ptr[HIST_AW-1:0]] <= s_axis_tdata;
      end
   end

   // Registered read port; addresses past the depth read as zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         hist_data <= '0;
      end else if ({1'b0, hist_addr} < DEPTH_P) begin
         hist_data <= hist_mem[hist_addr];
      end else begin
         hist_data <= '0;
      end
   end
`else
   logic unused_hist_addr;

   assign hist_data        = '0;
   assign unused_hist_addr = ^hist_addr;
`endif

endmodule

// File: tb/tb_pinc_stream_monitor.sv
// tb_pinc_stream_monitor
// Directed and randomized chirps for pinc_stream_monitor. Each chirp is a list
// of (value, hold) segments. Expected results come from that list: first and
// last values, the number of segments, hold-versus-dwell mismatches and step
// mismatches. Each error is timed at the cycle where its segment ends, so that
// a clear pulse can be modelled. History expectations follow PINC_MON_HIST_EN.
`timescale 1ns/1ps

module tb_pinc_stream_monitor;

   localparam int DATA_W     = 24;
   localparam int CNT_W      = 32;
   localparam int STEP       = 1;
   localparam int HIST_DEPTH = 512;
   localparam int HIST_AW    = 9;
   localparam int MASK       = (1 << DATA_W) - 1;

   logic               clk;
   logic               rst;
   logic [DATA_W-1:0]  s_axis_tdata;
   logic               s_axis_tvalid;
   logic               s_axis_tready;
   logic [CNT_W-1:0]   expected_dwell;
   logic               clear;
   logic               chirp_active;
   logic               chirp_done;
   logic [DATA_W-1:0]  pinc_first;
   logic [DATA_W-1:0]  pinc_last;
   logic [15:0]        step_count;
   logic               dwell_err;
   logic               step_err;
   logic [15:0]        err_count;
   logic [HIST_AW-1:0] hist_addr;
   logic [DATA_W-1:0]  hist_data;

   int checks = 0;
   int errors = 0;

   int m_err_count;
   bit m_dwell_flag;
   bit m_step_flag;
   int seg_val[$];
   int seg_hold[$];
   int hist_q[$];

   pinc_stream_monitor #(
      .DATA_W(DATA_W), .CNT_W(CNT_W), .STEP(STEP), .HIST_DEPTH(HIST_DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .expected_dwell(expected_dwell),
      .clear(clear), .chirp_active(chirp_active), .chirp_done(chirp_done),
      .pinc_first(pinc_first), .pinc_last(pinc_last), .step_count(step_count),
      .dwell_err(dwell_err), .step_err(step_err), .err_count(err_count),
      .hist_addr(hist_addr), .hist_data(hist_data)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic addSeg(input int v, input int h);
      seg_val.push_back(v & MASK);
      seg_hold.push_back(h);
   endtask

   task automatic clearSegs;
      seg_val.delete();
      seg_hold.delete();
   endtask

   task automatic modelReset;
      m_err_count  = 0;
      m_dwell_flag = 1'b0;
      m_step_flag  = 1'b0;
   endtask

   task automatic modelEvent(input bit d, input bit s);
      if (d) begin
         m_dwell_flag = 1'b1;
         m_err_count++;
      end
      if (s) begin
         m_step_flag = 1'b1;
         m_err_count++;
      end
      if (m_err_count > 65535) m_err_count = 65535;
   endtask

   // Drives one chirp from the segment list, scrambles expected_dwell after
   // the start cycle, optionally pulses clear at chirp cycle clear_at, then
   // checks the chirp summary against the segment-level model.
   task automatic applyStimulus(input int exp_dwell, input int clear_at, input string tag);
      int cyc;
      int t;
      int n;
      bit d;
      bit s;
      n = seg_val.size();
      expected_dwell = CNT_W'(exp_dwell);
      cyc = 0;
      for (int i = 0; i < n; i++) begin
         for (int h = 0; h < seg_hold[i]; h++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = DATA_W'(seg_val[i]);
            clear         = (cyc == clear_at);
            tick();
            if (cyc == 0) begin
               checkOutput({tag, ".active"}, chirp_active, 1);
               expected_dwell = $urandom;
            end
            cyc++;
         end
      end
      s_axis_tvalid = 1'b0;
      clear         = (cyc == clear_at);
      tick();
      clear = 1'b0;

      if (clear_at >= 0) modelReset();
      t = 0;
      for (int i = 0; i < n; i++) begin
         if (i > 0) begin
            d = (exp_dwell != 0) && (seg_hold[i-1] != exp_dwell);
            s = seg_val[i] != ((seg_val[i-1] + STEP) & MASK);
            if (t > clear_at) modelEvent(d, s);
         end
         t += seg_hold[i];
      end
      d = (exp_dwell != 0) && (seg_hold[n-1] != exp_dwell);
      if (t > clear_at) modelEvent(d, 1'b0);
      hist_q.delete();
      for (int i = 0; i < n && i < HIST_DEPTH; i++) hist_q.push_back(seg_val[i]);

      checkOutput({tag, ".done"}, chirp_done, 1);
      checkOutput({tag, ".active_end"}, chirp_active, 0);
      checkOutput({tag, ".first"}, pinc_first, seg_val[0]);
      checkOutput({tag, ".last"}, pinc_last, seg_val[n-1]);
      checkOutput({tag, ".steps"}, step_count, n - 1);
      checkOutput({tag, ".dwell_err"}, dwell_err, m_dwell_flag);
      checkOutput({tag, ".step_err"}, step_err, m_step_flag);
      checkOutput({tag, ".err_count"}, err_count, m_err_count);
      tick();
      checkOutput({tag, ".done_pulse"}, chirp_done, 0);
   endtask

   task automatic doClear(input string tag);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      modelReset();
      checkOutput({tag, ".err_count"}, err_count, 0);
      checkOutput({tag, ".dwell_err"}, dwell_err, 0);
      checkOutput({tag, ".step_err"}, step_err, 0);
   endtask

   task automatic readHist(input int n, input string tag);
      int exp;
      for (int a = 0; a < n; a++) begin
         hist_addr = HIST_AW'(a);
         tick();
`ifdef PINC_MON_HIST_EN
         exp = hist_q[a];
`else
         exp = 0;
`endif
         checkOutput($sformatf("%s.hist%0d", tag, a), hist_data, exp);
      end
   endtask

   // Directed steps followed by randomized chirps.
   initial begin
      int nseg;
      int v;
      int v2;
      int total;
      int clr;
      rst            = 1'b1;
      s_axis_tvalid  = 1'b0;
      s_axis_tdata   = '0;
      expected_dwell = '0;
      clear          = 1'b0;
      hist_addr      = '0;
      modelReset();
      tick();
      tick();
      checkOutput("rst.tready", s_axis_tready, 0);
      checkOutput("rst.active", chirp_active, 0);
      checkOutput("rst.err_count", err_count, 0);
      checkOutput("rst.first", pinc_first, 0);
      checkOutput("rst.hist", hist_data, 0);
      rst = 1'b0;
      tick();
      checkOutput("post_rst.tready", s_axis_tready, 1);
      tick();

      $display("[TB] nominal chirp");
      clearSegs();
      for (int i = 0; i < 5; i++) addSeg(100 + i, 3);
      applyStimulus(3, -1, "nominal");
      readHist(5, "nominal");

      $display("[TB] short dwell");
      clearSegs();
      addSeg(100, 3); addSeg(101, 3); addSeg(102, 2); addSeg(103, 3); addSeg(104, 3);
      applyStimulus(3, -1, "short_dwell");
      doClear("clear1");

      $display("[TB] skipped step");
      clearSegs();
      addSeg(100, 3); addSeg(101, 3); addSeg(102, 3); addSeg(104, 3);
      applyStimulus(3, -1, "skip_step");

      $display("[TB] clear on detection cycle");
      clearSegs();
      addSeg(100, 2); addSeg(101, 3);
      applyStimulus(3, 2, "clear_same");

      $display("[TB] single-cycle chirps");
      clearSegs();
      addSeg(7, 1);
      applyStimulus(1, -1, "single_ok");
      applyStimulus(2, -1, "single_bad");

      $display("[TB] wraparound");
      clearSegs();
      addSeg(MASK - 1, 2); addSeg(MASK, 2); addSeg(0, 2);
      applyStimulus(2, -1, "wrap");

      $display("[TB] reset mid-chirp");
      expected_dwell = 3;
      s_axis_tvalid  = 1'b1;
      s_axis_tdata   = 500;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      modelReset();
      checkOutput("midrst.tready", s_axis_tready, 0);
      checkOutput("midrst.active", chirp_active, 0);
      checkOutput("midrst.first", pinc_first, 0);
      checkOutput("midrst.last", pinc_last, 0);
      checkOutput("midrst.steps", step_count, 0);
      checkOutput("midrst.err_count", err_count, 0);
      checkOutput("midrst.errflags", {dwell_err, step_err}, 0);
      rst = 1'b0;
      tick();
      tick();
      tick();
      checkOutput("midrst.hold_active", chirp_active, 0);
      checkOutput("midrst.hold_done", chirp_done, 0);
      checkOutput("midrst.hold_tready", s_axis_tready, 1);
      s_axis_tvalid = 1'b0;
      tick();
      clearSegs();
      addSeg(200, 3); addSeg(201, 3);
      applyStimulus(3, -1, "after_rst");

      $display("[TB] randomized chirps");
      for (int k = 0; k < 20; k++) begin
         clearSegs();
         nseg = $urandom_range(1, 5);
         v = (k % 5 == 0) ? MASK - 1 : int'($urandom & MASK);
         total = 0;
         for (int i = 0; i < nseg; i++) begin
            addSeg(v, $urandom_range(1, 4));
            total += seg_hold[i];
            if ($urandom_range(0, 3) != 0) begin
               v = (v + STEP) & MASK;
            end else begin
               v2 = int'($urandom & MASK);
               while (v2 == v) v2 = int'($urandom & MASK);
               v = v2;
            end
         end
         clr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, total) : -1;
         repeat ($urandom_range(0, 2)) tick();
         applyStimulus($urandom_range(0, 4), clr, $sformatf("rand%0d", k));
      end
      readHist(seg_val.size(), "rand_hist");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
